// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V control FSM with memory-ready handshake, wait timeout and traps
// Optional retired-instruction counter enabled by MULTICYCLE_CONTROL_PERF_EN
module multicycle_control #(
    parameter int ALU_OP_WIDTH = 3,
    parameter int TIMEOUT_W    = 4,
    parameter int PERF_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              OP_i,
    input  logic                    Zero_i,
    input  logic                    Mem_Ready_i,
    output logic                    PC_Write_o,
    output logic                    PC_Src_o,
    output logic                    IR_Write_o,
    output logic                    I_or_D_o,
    output logic                    Mem_Read_o,
    output logic                    Mem_Write_o,
    output logic                    Reg_Write_o,
    output logic [1:0]              Mem_to_Reg_o,
    output logic [1:0]              ALU_Src_A_o,
    output logic [1:0]              ALU_Src_B_o,
    output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
    output logic [3:0]              State_o,
    output logic                    Illegal_o,
    output logic                    Mem_Timeout_o
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [PERF_W-1:0]       Instr_Count_o
`endif
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
        MEM_ADDR = 4'd4, MEM_LOAD = 4'd5, MEM_STORE = 4'd6, WB_ALU = 4'd7,
        WB_MEM = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
        LUI = 4'd12, TRAP = 4'd15
    } state_e;
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 ill_q, ill_d, to_q, to_d;
    logic                 wait_st;
    logic [2:0]           alu_op;
    // State, wait counter and sticky trap flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end
    // Next-state, handshake timeout and per-state datapath enables
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        ill_d        = ill_q;
        to_d         = to_q;
        wait_st      = 1'b0;
        PC_Write_o   = 1'b0;
        PC_Src_o     = 1'b0;
        IR_Write_o   = 1'b0;
        I_or_D_o     = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Reg_Write_o  = 1'b0;
        Mem_to_Reg_o = 2'b00;
        ALU_Src_A_o  = 2'b00;
        ALU_Src_B_o  = 2'b00;
        alu_op       = 3'b000;
        case (state_q)
            FETCH: begin
                wait_st     = 1'b1;
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b01;
                alu_op      = 3'b011;
                if (Mem_Ready_i) begin
                    IR_Write_o = 1'b1;
                    PC_Write_o = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
                alu_op      = 3'b011;
                case (OP_i)
                    7'h33:         state_d = EXEC_R;
                    7'h13:         state_d = EXEC_I;
                    7'h03, 7'h23:  state_d = MEM_ADDR;
                    7'h63:         state_d = BRANCH;
                    7'h6F:         state_d = JAL;
                    7'h67:         state_d = JALR;
                    7'h37:         state_d = LUI;
                    default: begin
                        state_d = TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ALU_Src_A_o = 2'b01;
                state_d     = WB_ALU;
            end
            EXEC_I: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                alu_op      = 3'b001;
                state_d     = WB_ALU;
            end
            LUI: begin
                ALU_Src_B_o = 2'b10;
                alu_op      = 3'b010;
                state_d     = WB_ALU;
            end
            MEM_ADDR: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                alu_op      = 3'b011;
                state_d     = (OP_i == 7'h03) ? MEM_LOAD : MEM_STORE;
            end
            MEM_LOAD: begin
                wait_st    = 1'b1;
                I_or_D_o   = 1'b1;
                Mem_Read_o = 1'b1;
                if (Mem_Ready_i) state_d = WB_MEM;
            end
            MEM_STORE: begin
                wait_st     = 1'b1;
                I_or_D_o    = 1'b1;
                Mem_Write_o = 1'b1;
                if (Mem_Ready_i) state_d = FETCH;
            end
            WB_ALU: begin
                Reg_Write_o = 1'b1;
                state_d     = FETCH;
            end
            WB_MEM: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
                state_d      = FETCH;
            end
            BRANCH: begin
                ALU_Src_A_o = 2'b01;
                alu_op      = 3'b100;
                PC_Src_o    = 1'b1;
                PC_Write_o  = Zero_i;
                state_d     = FETCH;
            end
            JAL: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                state_d      = FETCH;
            end
            JALR: begin
                ALU_Src_A_o  = 2'b01;
                ALU_Src_B_o  = 2'b10;
                alu_op       = 3'b011;
                PC_Write_o   = 1'b1;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                state_d      = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
        if (wait_st && !Mem_Ready_i) begin
            if (cnt_q == CNT_MAX) begin
                state_d = TRAP;
                to_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
    assign ALU_Op_o      = ALU_OP_WIDTH'(alu_op);
    assign State_o       = state_q;
    assign Illegal_o     = ill_q;
    assign Mem_Timeout_o = to_q;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [PERF_W-1:0] perf_q;
    // Count retirements: any return to FETCH from a working state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else if (state_q != FETCH && state_q != TRAP && state_d == FETCH) perf_q <= perf_q + 1'b1;
    end
    assign Instr_Count_o = perf_q;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multi-cycle control FSM
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op, op2;
    logic       zero, rdy, rdy2;
    logic       pcw, pcs, irw, iod, mrd, mwr, rgw, ill, tmo;
    logic [1:0] m2r, sa, sb;
    logic [2:0] aop;
    logic [3:0] st;
    logic       pcw2, pcs2, irw2, iod2, mrd2, mwr2, rgw2, ill2, tmo2;
    logic [1:0] m2r2, sa2, sb2;
    logic [2:0] aop2;
    logic [3:0] st2;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [31:0] icnt, icnt2;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP_i(op), .Zero_i(zero), .Mem_Ready_i(rdy),
        .PC_Write_o(pcw), .PC_Src_o(pcs), .IR_Write_o(irw), .I_or_D_o(iod),
        .Mem_Read_o(mrd), .Mem_Write_o(mwr), .Reg_Write_o(rgw), .Mem_to_Reg_o(m2r),
        .ALU_Src_A_o(sa), .ALU_Src_B_o(sb), .ALU_Op_o(aop), .State_o(st),
        .Illegal_o(ill), .Mem_Timeout_o(tmo)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        , .Instr_Count_o(icnt)
`endif
    );

    multicycle_control #(.TIMEOUT_W(2)) dut2 (
        .clk(clk), .reset(reset), .OP_i(op2), .Zero_i(1'b0), .Mem_Ready_i(rdy2),
        .PC_Write_o(pcw2), .PC_Src_o(pcs2), .IR_Write_o(irw2), .I_or_D_o(iod2),
        .Mem_Read_o(mrd2), .Mem_Write_o(mwr2), .Reg_Write_o(rgw2), .Mem_to_Reg_o(m2r2),
        .ALU_Src_A_o(sa2), .ALU_Src_B_o(sb2), .ALU_Op_o(aop2), .State_o(st2),
        .Illegal_o(ill2), .Mem_Timeout_o(tmo2)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        , .Instr_Count_o(icnt2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b0; op = 7'h33; zero = 1'b0; rdy = 1'b1; op2 = 7'h23; rdy2 = 1'b1;
        step(); step();
        chk("rst_state", 32'(st), 0);
        chk("rst_ill", 32'(ill), 0);
        chk("rst_tmo", 32'(tmo), 0);
        reset = 1'b1;
        chk("r_fetch_ir", 32'(irw), 1);
        chk("r_fetch_pcw", 32'(pcw), 1);
        chk("r_fetch_ctl", {27'(0), mrd, sb, aop}, {27'(0), 1'b1, 2'b01, 3'b011});
        chk("r_fetch_rgw", 32'(rgw), 0);
        step();
        chk("r_dec_state", 32'(st), 1);
        chk("r_dec_ctl", {25'(0), sa, sb, aop}, {25'(0), 2'b10, 2'b10, 3'b011});
        chk("r_dec_rgw", 32'(rgw), 0);
        step();
        chk("r_exe_state", 32'(st), 2);
        chk("r_exe_ctl", {25'(0), sa, sb, aop}, {25'(0), 2'b01, 2'b00, 3'b000});
        chk("r_exe_rgw", 32'(rgw), 0);
        step();
        chk("r_wb_state", 32'(st), 7);
        chk("r_wb_rgw", 32'(rgw), 1);
        step();
        chk("r_ret_state", 32'(st), 0);
        chk("r_ret_rgw", 32'(rgw), 0);
        op = 7'h03;
        step();
        step();
        chk("ld_addr_state", 32'(st), 4);
        rdy = 1'b0;
        chk("ld_addr_noreq", 32'(mrd), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_wait_state", 32'(st), 5);
            chk("ld_wait_req", {30'(0), mrd, iod}, 32'h3);
        end
        rdy = 1'b1;
        chk("ld_ready_req", {30'(0), mrd, iod}, 32'h3);
        step();
        chk("ld_wb_state", 32'(st), 8);
        chk("ld_wb_ctl", {29'(0), rgw, m2r}, {29'(0), 1'b1, 2'b01});
        step();
        chk("ld_ret_state", 32'(st), 0);
        op = 7'h63;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'(z);
            step();
            step();
            chk("br_state", 32'(st), 9);
            chk("br_pcs", 32'(pcs), 1);
            chk("br_pcw", 32'(pcw), 32'(z));
            chk("br_alu", {29'(0), aop}, 32'h4);
            step();
            chk("br_ret_state", 32'(st), 0);
        end
        op = 7'h6F;
        step();
        step();
        chk("jal_state", 32'(st), 10);
        chk("jal_ctl", {27'(0), pcw, pcs, rgw, m2r}, {27'(0), 1'b1, 1'b1, 1'b1, 2'b10});
        step();
        op = 7'h13;
        step();
        step();
        chk("ei_state", 32'(st), 3);
        chk("ei_ctl", {25'(0), sa, sb, aop}, {25'(0), 2'b01, 2'b10, 3'b001});
        step();
        step();
        op = 7'h00;
        step();
        step();
        chk("ill_state", 32'(st), 15);
        chk("ill_flag", 32'(ill), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ill_hold", {27'(0), st, ill}, {27'(0), 4'hF, 1'b1});
            chk("trap_en", {30'(0), mrd, pcw}, 0);
        end
        #2 reset = 1'b0;
        #1;
        chk("ill_rst_state", 32'(st), 0);
        chk("ill_rst_flag", 32'(ill), 0);
        step();
        reset = 1'b1;
        op = 7'h23;
        step();
        step();
        chk("st_addr_state", 32'(st), 4);
        rdy = 1'b0;
        step();
        chk("st_state", 32'(st), 6);
        chk("st_req", {30'(0), mwr, iod}, 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("async_mwr", 32'(mwr), 0);
        chk("async_state", 32'(st), 0);
        step();
        reset = 1'b1;
        rdy2 = 1'b1;
        step();
        step();
        chk("to_addr_state", 32'(st2), 4);
        rdy2 = 1'b0;
        step();
        chk("to_st0", 32'(st2), 6);
        step();
        chk("to_st1", 32'(st2), 6);
        step();
        chk("to_st2", {27'(0), st2, tmo2}, {27'(0), 4'h6, 1'b0});
        step();
        chk("to_trap", 32'(st2), 15);
        chk("to_flag", 32'(tmo2), 1);
        chk("to_ill", 32'(ill2), 0);
        chk("to_mwr", 32'(mwr2), 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        reset = 1'b0;
        #1;
        chk("perf_rst", icnt, 0);
        step();
        reset = 1'b1;
        op = 7'h33;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("perf_cnt", icnt, 5);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
